// File: rtl/pc_sequencer.sv
// Program counter and branch sequencer for the multicycle SimpleRISC CPU.
// Handles conditional branches, call/return through a circular return-address stack, and halt.
module pc_sequencer #(
  parameter int AW        = 9,
  parameter int IMMW      = 8,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pc_en,
  input  logic                         is_branch,
  input  logic                         is_call,
  input  logic                         is_ret,
  input  logic                         is_halt,
  input  logic [2:0]                   cond,
  input  logic [IMMW-1:0]              imm,
  input  logic                         N,
  input  logic                         V,
  input  logic                         Z,
  output logic [AW-1:0]                pc,
  output logic [AW-1:0]                next_pc,
  output logic                         taken,
  output logic                         halted,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   stack_mem [RAS_DEPTH];
  logic [PW-1:0]   sp_reg;
  logic [PW-1:0]   sp_top;
  logic [AW-1:0]   seq, tgt, imm_ext;
  logic            cond_true;
  logic            advance;
  logic            do_push, do_pop, pop_empty;

  assign imm_ext = AW'($signed(imm));
  assign seq     = pc + AW'(1);
  assign tgt     = seq + imm_ext;
  assign sp_top  = sp_reg - PW'(1);
  assign advance = pc_en && (state_reg == RUN);
  assign halted  = (state_reg == HALT);

  always_comb begin
    case (cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = Z;
      3'b010:  cond_true = !Z;
      3'b011:  cond_true = N ^ V;
      3'b100:  cond_true = (N ^ V) | Z;
      default: cond_true = 1'b0;
    endcase
  end

  // Selection and stack actions follow the strobe priority halt > ret > call > branch.
  always_comb begin
    next_pc    = seq;
    state_next = state_reg;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    pop_empty  = 1'b0;
    if (state_reg == HALT || is_halt) begin
      next_pc = pc;
    end else if (is_ret) begin
      if (ras_count != '0) next_pc = stack_mem[sp_top];
    end else if (is_call || (is_branch && cond_true)) begin
      next_pc = tgt;
    end
    if (advance) begin
      if (is_halt) begin
        state_next = HALT;
      end else if (is_ret) begin
        if (ras_count != '0) do_pop = 1'b1;
        else                 pop_empty = 1'b1;
      end else if (is_call) begin
        do_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= RUN;
      pc        <= AW'(RESET_PC);
      taken     <= 1'b0;
      sp_reg    <= '0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (advance) begin
        pc    <= next_pc;
        taken <= !is_halt && (next_pc != seq);
      end else begin
        taken <= 1'b0;
      end
      if (do_push) begin
        sp_reg <= sp_reg + PW'(1);
        // A full stack overwrites its oldest entry, so the count stays saturated.
        if (ras_count == CW'(RAS_DEPTH)) ras_ovf   <= 1'b1;
        else                             ras_count <= ras_count + CW'(1);
      end
      if (do_pop) begin
        sp_reg    <= sp_top;
        ras_count <= ras_count - CW'(1);
      end
      if (pop_empty) ras_unf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && do_push) stack_mem[sp_reg] <= seq;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random strobes,
// compared against a queue-based reference model of the sequencer.
module tb_pc_sequencer;

  localparam int AW    = 9;
  localparam int IMMW  = 8;
  localparam int DEPTH = 4;
  localparam int RPC   = 0;
  localparam int MASK  = (1 << AW) - 1;

  logic            clk;
  logic            reset, pc_en, is_branch, is_call, is_ret, is_halt;
  logic [2:0]      cond;
  logic [IMMW-1:0] imm;
  logic            N, V, Z;
  logic [AW-1:0]   pc, next_pc;
  logic            taken, halted, ras_ovf, ras_unf;
  logic [$clog2(DEPTH):0] ras_count;

  int errors = 0;
  int checks = 0;

  int m_pc;
  bit m_taken, m_halted, m_ovf, m_unf;
  int q[$];

  pc_sequencer #(.AW(AW), .IMMW(IMMW), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .is_branch(is_branch), .is_call(is_call),
    .is_ret(is_ret), .is_halt(is_halt), .cond(cond), .imm(imm), .N(N), .V(V), .Z(Z),
    .pc(pc), .next_pc(next_pc), .taken(taken), .halted(halted), .ras_count(ras_count),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_cond(input int c, input bit n, input bit v, input bit z);
    case (c)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return n != v;
      4: return (n != v) || z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_next(input bit br, input bit cl, input bit rt, input bit hl,
                                input int cnd, input int im, input bit n, input bit v, input bit z);
    int seq, simm, tgt;
    seq  = (m_pc + 1) & MASK;
    simm = ((im & 255) >= 128) ? (im & 255) - 256 : (im & 255);
    tgt  = (m_pc + 1 + simm) & MASK;
    if (m_halted || hl) return m_pc;
    if (rt) return (q.size() > 0) ? q[$] : seq;
    if (cl || (br && m_cond(cnd, n, v, z))) return tgt;
    return seq;
  endfunction

  task automatic m_update(input bit rst_n, input bit en, input bit br, input bit cl, input bit rt,
                          input bit hl, input int cnd, input int im, input bit n, input bit v, input bit z);
    int nxt, seq;
    if (!rst_n) begin
      m_pc = RPC; m_taken = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
      q.delete();
    end else if (en && !m_halted) begin
      nxt = m_next(br, cl, rt, hl, cnd, im, n, v, z);
      seq = (m_pc + 1) & MASK;
      m_taken = (nxt != seq) && !hl;
      if (hl) m_halted = 1;
      else if (rt) begin
        if (q.size() > 0) void'(q.pop_back());
        else m_unf = 1;
      end else if (cl) begin
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          m_ovf = 1;
        end
        q.push_back(seq);
      end
      m_pc = nxt;
    end else begin
      m_taken = 0;
    end
  endtask

  task automatic step(input bit rst_n, input bit en, input bit br, input bit cl, input bit rt,
                      input bit hl, input int cnd, input int im, input bit n, input bit v, input bit z);
    reset = rst_n; pc_en = en; is_branch = br; is_call = cl; is_ret = rt; is_halt = hl;
    cond = cnd[2:0]; imm = im[IMMW-1:0]; N = n; V = v; Z = z;
    #2;
    chk("next_pc", 32'(next_pc), 32'(m_next(br, cl, rt, hl, cnd, im, n, v, z)));
    @(posedge clk);
    m_update(rst_n, en, br, cl, rt, hl, cnd, im, n, v, z);
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("taken", 32'(taken), 32'(m_taken));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("ras_count", 32'(ras_count), 32'(q.size()));
    chk("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
    chk("ras_unf", 32'(ras_unf), 32'(m_unf));
    $display("t=%0t rst=%b en=%b br=%b call=%b ret=%b halt=%b cond=%0d imm=%h -> pc=%h taken=%b halted=%b cnt=%0d ovf=%b unf=%b",
             $time, rst_n, en, br, cl, rt, hl, cnd, im[IMMW-1:0], pc, taken, halted, ras_count, ras_ovf, ras_unf);
  endtask

  task automatic br_always(input int im);
    step(1, 1, 1, 0, 0, 0, 0, im, 0, 0, 0);
  endtask

  initial begin
    reset = 0; pc_en = 0; is_branch = 0; is_call = 0; is_ret = 0; is_halt = 0;
    cond = 0; imm = 0; N = 0; V = 0; Z = 0;
    m_pc = RPC; m_taken = 0; m_halted = 0; m_ovf = 0; m_unf = 0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", 32'(pc), 32'(RPC));
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("seq_pc", 32'(pc), 32'(k));
      chk("seq_taken", 32'(taken), 32'(0));
    end

    br_always(8'h0C);
    chk("goto_10", 32'(pc), 32'h010);
    step(1, 1, 1, 0, 0, 0, 1, 8'hFE, 0, 0, 1);
    chk("beq_taken_pc", 32'(pc), 32'h00F);
    chk("beq_taken_flag", 32'(taken), 32'(1));
    br_always(0);
    step(1, 1, 1, 0, 0, 0, 1, 8'hFE, 0, 0, 0);
    chk("beq_not_taken_pc", 32'(pc), 32'h011);

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    br_always(8'hFE);
    chk("goto_1ff", 32'(pc), 32'h1FF);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq_wrap", 32'(pc), 32'h000);
    br_always(8'hFD);
    chk("goto_1fe", 32'(pc), 32'h1FE);
    br_always(8'h01);
    chk("tgt_wrap", 32'(pc), 32'h000);

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    br_always(8'h0F);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 1, 0, 0, 0, 8'h0F, 0, 0, 0);
      chk("call_pc", 32'(pc), 32'(32'h020 + 32'h010 * k));
    end
    chk("call_count_sat", 32'(ras_count), 32'(4));
    chk("call_ovf", 32'(ras_ovf), 32'(1));
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("ret_pc", 32'(pc), 32'(32'h051 - 32'h010 * k));
    end
    step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("ret_empty_pc", 32'(pc), 32'h022);
    chk("ret_unf", 32'(ras_unf), 32'(1));

    step(1, 1, 0, 1, 0, 0, 0, 8'h0D, 0, 0, 0);
    chk("call_30", 32'(pc), 32'h030);
    step(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("halt_set", 32'(halted), 32'(1));
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("halt_pc_frozen", 32'(pc), 32'h030);
      chk("halt_stack_frozen", 32'(ras_count), 32'(1));
    end
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("halt_exit_pc", 32'(pc), 32'(RPC));
    chk("halt_exit_flag", 32'(halted), 32'(0));

    br_always(8'h0F);
    step(1, 1, 0, 1, 0, 0, 0, 8'h0F, 0, 0, 0);
    chk("pre_reset_count", 32'(ras_count), 32'(1));
    step(0, 1, 0, 1, 0, 0, 0, 8'h0F, 0, 0, 0);
    chk("reset_vs_call_pc", 32'(pc), 32'(RPC));
    chk("reset_vs_call_count", 32'(ras_count), 32'(0));

    for (int k = 0; k < 400; k++) begin
      bit rst_n;
      rst_n = ($urandom_range(0, 99) >= 3);
      if (m_halted && $urandom_range(0, 5) == 0) rst_n = 0;
      step(rst_n, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
